// File: rtl/cp_sync_ctrl.sv
// Sequencing controller for the CP-correlation timing-sync datapath:
// flush, fill wait, then a max-search over SEARCH_LEN metric samples.
module cp_sync_ctrl #(
  parameter int METRIC_W   = 16,
  parameter int FLUSH_CYC  = 2,
  parameter int FILL_CYC   = 88,
  parameter int SEARCH_LEN = 80,
  parameter int IDX_W      = $clog2(SEARCH_LEN)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic signed [METRIC_W-1:0] metric_in,
  output logic                       dp_rst,
  output logic                       busy,
  output logic                       done,
  output logic [IDX_W-1:0]           peak_idx,
  output logic signed [METRIC_W-1:0] peak_val
);

  localparam int CNT_MAX = (FLUSH_CYC > FILL_CYC)
                         ? ((FLUSH_CYC > SEARCH_LEN) ? FLUSH_CYC : SEARCH_LEN)
                         : ((FILL_CYC  > SEARCH_LEN) ? FILL_CYC  : SEARCH_LEN);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] FLUSH_LD = CNT_W'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] FILL_LD  = CNT_W'(FILL_CYC - 1);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(SEARCH_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_FILL, S_SEARCH, S_DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] k;
  logic             upd;

  // The shared counter counts down through SEARCH, so k is its complement.
  assign k = LAST - cnt;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_FLUSH;
          cnt_n   = FLUSH_LD;
        end
      end
      S_FLUSH: begin
        if (cnt == '0) begin
          state_n = S_FILL;
          cnt_n   = FILL_LD;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_FILL: begin
        if (cnt == '0) begin
          state_n = S_SEARCH;
          cnt_n   = LAST;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_SEARCH: begin
        if (cnt == '0) begin
          state_n = S_DONE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
    if (abort) begin
      state_n = S_IDLE;
      cnt_n   = '0;
    end
  end

  // An aborting cycle does not fold its sample into the peak.
  assign upd = (state == S_SEARCH) && !abort &&
               ((cnt == LAST) || (metric_in > peak_val));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      dp_rst   <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      peak_idx <= '0;
      peak_val <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      // Outputs are registered from the next state so they align with it.
      dp_rst <= (state_n == S_IDLE) || (state_n == S_FLUSH);
      busy   <= (state_n == S_FLUSH) || (state_n == S_FILL) ||
                (state_n == S_SEARCH);
      done   <= (state_n == S_DONE);
      if (upd) begin
        peak_idx <= k[IDX_W-1:0];
        peak_val <= metric_in;
      end
    end
  end

endmodule

// File: doc/cp_sync_ctrl.md
# cp_sync_ctrl

Sequencing controller for the CP-correlation timing-sync datapath: holds the energy/correlation pipeline (phi sliding-window energy and its companion correlator) in reset while idle, flushes it on `start`, and waits out pipeline fill plus window warm-up. It then scans the combined timing metric over a fixed search window and reports the index and value of its maximum. It sits between the frame-level control FSM and the sample-rate datapath, which streams one sample per clock with no enable.

## Interface
- `METRIC_W`, 16: width of signed timing metric input (Q-format set by the datapath, compared as a plain signed integer)
- `FLUSH_CYC`, 2: cycles `dp_rst` is held after `start` (≥1)
- `FILL_CYC`, 88: cycles from end of flush to first valid metric (N=64 + L=16 + datapath latency 8)
- `SEARCH_LEN`, 80: number of metric samples scanned (≥2)
- `IDX_W`, $clog2(SEARCH_LEN): width of peak index
- `clk`  in  1  single clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to begin a search; honoured only in IDLE
- `abort`  in  1  cancels any operation; returns to IDLE
- `metric_in`  in  METRIC_W  signed metric from the datapath, one per cycle
- `dp_rst`  out  1  active-high synchronous reset driven to the datapath
- `busy`  out  1  high in FLUSH, FILL, SEARCH
- `done`  out  1  one-cycle pulse when results are valid
- `peak_idx`  out  IDX_W  search-relative index of the maximum metric
- `peak_val`  out  METRIC_W  maximum metric value

## Operation
- States: IDLE, FLUSH, FILL, SEARCH, DONE; one down-counter (width covers max(FLUSH_CYC, FILL_CYC, SEARCH_LEN)) shared across states.
- IDLE: `dp_rst`=1. `start`=1 → FLUSH, counter loaded with FLUSH_CYC-1.
- FLUSH: `dp_rst`=1 for exactly FLUSH_CYC cycles. At counter 0 → FILL, load FILL_CYC-1.
- FILL: `dp_rst`=0. `metric_in` is ignored. At counter 0 → SEARCH, load SEARCH_LEN-1; the search index is reset to 0.
- SEARCH: `dp_rst`=0. On search cycle k (k=0..SEARCH_LEN-1), sample `metric_in`:
  - k=0: load `peak_val`=metric_in, `peak_idx`=0 unconditionally.
  - k>0: if metric_in > peak_val (strict signed compare), load both; ties keep the earlier index.
  - After k=SEARCH_LEN-1 → DONE.
- DONE: `done`=1 for one cycle, `dp_rst`=0; → IDLE next cycle.
- `peak_idx`/`peak_val` are held from DONE until the next SEARCH k=0 update. They are not cleared by entering FLUSH.
- `abort`=1 in any state → IDLE next cycle. No `done`; peak outputs keep their current (possibly partial) values. `abort` has priority over `start` in the same cycle, so `start`+`abort` in IDLE stays in IDLE.
- `start` outside IDLE is ignored and not queued.

## Timing
- Reset (`rst_n`=0, asynchronous): state IDLE, `dp_rst`=1, `busy`=0, `done`=0, `peak_idx`=0, `peak_val`=0, counter 0. Reset mid-operation aborts immediately, with no `done`.
- All outputs are registered.
- `start` high at edge t gives FLUSH during t+1..t+FLUSH_CYC, FILL during the next FILL_CYC cycles, and SEARCH during the next SEARCH_LEN cycles.
- `done` is high at cycle t+FLUSH_CYC+FILL_CYC+SEARCH_LEN+1.
- With defaults: first searched metric at cycle t+91, done at t+171.
- `busy` rises at t+1 and falls in the DONE cycle.
- Back-to-back operation: `start` in the first IDLE cycle after DONE is accepted; the minimum start-to-start period is FLUSH_CYC+FILL_CYC+SEARCH_LEN+2.

## Test plan
- Basic peak: defaults; search metrics 0 except value 300 at k=37 → done at t+171, peak_idx=37, peak_val=300; `dp_rst` high t+1..t+2, low from t+3.
- Tie and negatives: all search metrics −100, except −5 at k=12 and −5 at k=50 → peak_idx=12, peak_val=−5. Verify FILL-phase metric 32767 is ignored.
- Edge indices: max at k=0 in one run and at k=79 in the next run (back-to-back start right after DONE) → idx 0 then 79, each with a single `done` pulse.
- Abort: `abort` asserted at SEARCH k=20 → IDLE next cycle, no `done`, `dp_rst`=1, `busy`=0; a subsequent `start` gives a normal full-length run.
- Start while busy: extra `start` pulses in FLUSH, FILL and SEARCH → no timing change, exactly one `done` at t+171.
- Async reset: drop `rst_n` mid-FILL, between clock edges → outputs immediately at reset values (`dp_rst`=1, `busy`=0, peak=0); release, then `start` → normal run.
